plot_sink: RTL and testbench



---
 rtl/plot_sink.sv | 178 +++++++++++++++++
 tb/tb_plot_sink.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/plot_sink.sv
// plot_sink: consumer end of the pixel-plot interface.
// Captures accepted plots into a WIDTH x HEIGHT, 3-bit-per-pixel frame
// store, keeps plot statistics and a bounding box, and offers a registered
// read-back port that is live in every state.
//
// Plot acceptance: a plot is taken on any rising edge where ready=1,
// vga_plot=1 and clear_start=0. ready is the only form of backpressure, and
// the plot inputs are never stalled: a plot presented while ready=0 is
// discarded, not held. One plot per cycle can be sustained.
module plot_sink #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] vga_x,
  input  logic [6:0] vga_y,
  input  logic [2:0] vga_colour,
  input  logic       vga_plot,
  output logic       ready,
  input  logic       clear_start,
  output logic       clear_done,
  input  logic [7:0] rd_x,
  input  logic [6:0] rd_y,
  output logic [2:0] rd_colour,
  output logic [15:0] plot_count,
  output logic [15:0] oob_count,
  output logic       bbox_valid,
  output logic [7:0] bbox_xmin,
  output logic [7:0] bbox_xmax,
  output logic [6:0] bbox_ymin,
  output logic [6:0] bbox_ymax,
  output logic       state_dbg
);

  localparam int          DEPTH     = WIDTH * HEIGHT;
  localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);
  localparam logic [8:0]  WIDTH_L   = 9'(WIDTH);
  localparam logic [7:0]  HEIGHT_L  = 8'(HEIGHT);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t      state;
  logic [14:0] clr_addr;

  // Frame store; contents are only meaningful after a full clear pass.
  logic [2:0] mem [DEPTH];

  logic        plot_in_range;
  logic [14:0] plot_addr;
  logic        plot_take;
  logic        plot_oob;
  logic        rd_in_range;
  logic [14:0] rd_addr;

  logic        mem_we;
  logic [14:0] mem_waddr;
  logic [2:0]  mem_wdata;

  assign state_dbg = state;

  // Coordinate decode for the plot and read ports (full-width address math).
  always_comb begin
    plot_in_range = ({1'b0, vga_x} < WIDTH_L) && ({1'b0, vga_y} < HEIGHT_L);
    plot_addr     = 15'(vga_y) * 15'(WIDTH) + 15'(vga_x);
    rd_in_range   = ({1'b0, rd_x} < WIDTH_L) && ({1'b0, rd_y} < HEIGHT_L);
    rd_addr       = rd_in_range ? (15'(rd_y) * 15'(WIDTH) + 15'(rd_x)) : 15'd0;
    plot_take     = (state == S_RUN) && !clear_start && vga_plot && plot_in_range;
    plot_oob      = (state == S_RUN) && !clear_start && vga_plot && !plot_in_range;
  end

  // Single write port: the clear sweep owns it in CLEAR, accepted plots in RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_addr;
    mem_wdata = 3'b000;
    if (rst_n) begin
      if (state == S_CLEAR) begin
        mem_we = 1'b1;
      end else if (plot_take) begin
        mem_we    = 1'b1;
        mem_waddr = plot_addr;
        mem_wdata = vga_colour;
      end
    end
  end

  // Frame store write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read-back; a same-edge write is not visible (read-before-write).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_colour <= 3'b000;
    end else begin
      rd_colour <= rd_in_range ? mem[rd_addr] : 3'b000;
    end
  end

  // Control FSM with statistics and bounding box, all updated on the write edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_CLEAR;
      clr_addr   <= 15'd0;
      ready      <= 1'b0;
      clear_done <= 1'b0;
      plot_count <= 16'd0;
      oob_count  <= 16'd0;
      bbox_valid <= 1'b0;
      bbox_xmin  <= 8'd0;
      bbox_xmax  <= 8'd0;
      bbox_ymin  <= 7'd0;
      bbox_ymax  <= 7'd0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        S_CLEAR: begin
          if (clr_addr == LAST_ADDR) begin
            state      <= S_RUN;
            clr_addr   <= 15'd0;
            ready      <= 1'b1;
            clear_done <= 1'b1;
          end else begin
            clr_addr <= clr_addr + 15'd1;
          end
        end
        S_RUN: begin
          if (clear_start) begin
            state      <= S_CLEAR;
            clr_addr   <= 15'd0;
            ready      <= 1'b0;
            plot_count <= 16'd0;
            oob_count  <= 16'd0;
            bbox_valid <= 1'b0;
            bbox_xmin  <= 8'd0;
            bbox_xmax  <= 8'd0;
            bbox_ymin  <= 7'd0;
            bbox_ymax  <= 7'd0;
          end else begin
            if (plot_take) begin
              if (plot_count != 16'hFFFF) begin
                plot_count <= plot_count + 16'd1;
              end
              bbox_valid <= 1'b1;
              if (!bbox_valid) begin
                bbox_xmin <= vga_x;
                bbox_xmax <= vga_x;
                bbox_ymin <= vga_y;
                bbox_ymax <= vga_y;
              end else begin
                if (vga_x < bbox_xmin) bbox_xmin <= vga_x;
                if (vga_x > bbox_xmax) bbox_xmax <= vga_x;
                if (vga_y < bbox_ymin) bbox_ymin <= vga_y;
                if (vga_y > bbox_ymax) bbox_ymax <= vga_y;
              end
            end
            if (plot_oob && (oob_count != 16'hFFFF)) begin
              oob_count <= oob_count + 16'd1;
            end
          end
        end
        default: begin
          state    <= S_CLEAR;
          clr_addr <= 15'd0;
          ready    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plot_sink.sv
// Bench for plot_sink: directed steps from reset through clears, plots,
// read-back and a randomized plot burst checked against a frame model.
module tb_plot_sink;

  logic        clk;
  logic        rst_n;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        ready;
  logic        clear_start;
  logic        clear_done;
  logic [7:0]  rd_x;
  logic [6:0]  rd_y;
  logic [2:0]  rd_colour;
  logic [15:0] plot_count;
  logic [15:0] oob_count;
  logic        bbox_valid;
  logic [7:0]  bbox_xmin;
  logic [7:0]  bbox_xmax;
  logic [6:0]  bbox_ymin;
  logic [6:0]  bbox_ymax;
  logic        state_dbg;

  int checks;
  int failures;

  // Frame model: plain array of pixels plus statistics.
  int m_mem [19200];
  int m_pc;
  int m_oob;
  int m_bv;
  int m_xmin, m_xmax, m_ymin, m_ymax;
  logic [14:0] exp_q [$];

  plot_sink #(.WIDTH(160), .HEIGHT(120)) dut (
    .clk(clk), .rst_n(rst_n),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .ready(ready), .clear_start(clear_start), .clear_done(clear_done),
    .rd_x(rd_x), .rd_y(rd_y), .rd_colour(rd_colour),
    .plot_count(plot_count), .oob_count(oob_count),
    .bbox_valid(bbox_valid), .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax),
    .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax), .state_dbg(state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 19200; i++) m_mem[i] = 0;
    m_pc = 0; m_oob = 0; m_bv = 0;
    m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0;
  endfunction

  function automatic int model_read(input int x, input int y);
    if (x < 160 && y < 120) return m_mem[y * 160 + x];
    return 0;
  endfunction

  function automatic void model_plot(input int x, input int y, input int c);
    if (x < 160 && y < 120) begin
      m_mem[y * 160 + x] = c;
      if (m_pc < 65535) m_pc++;
      if (m_bv == 0) begin
        m_xmin = x; m_xmax = x; m_ymin = y; m_ymax = y; m_bv = 1;
      end else begin
        if (x < m_xmin) m_xmin = x;
        if (x > m_xmax) m_xmax = x;
        if (y < m_ymin) m_ymin = y;
        if (y > m_ymax) m_ymax = y;
      end
    end else if (m_oob < 65535) begin
      m_oob++;
    end
  endfunction

  // Drivers: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic plot(input int x, input int y, input int c);
    vga_x = 8'(x); vga_y = 7'(y); vga_colour = 3'(c); vga_plot = 1'b1;
    step();
    vga_plot = 1'b0;
    model_plot(x, y, c);
  endtask

  task automatic check_read(input string tag, input int x, input int y);
    rd_x = 8'(x); rd_y = 7'(y);
    step();
    check(tag, 32'(rd_colour), 32'(model_read(x, y)));
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_pc"}, 32'(plot_count), 32'(m_pc));
    check({tag, "_oob"}, 32'(oob_count), 32'(m_oob));
    check({tag, "_bv"}, 32'(bbox_valid), 32'(m_bv));
    check({tag, "_bbox"}, {bbox_xmin, bbox_xmax, 1'b0, bbox_ymin, 1'b0, bbox_ymax},
          {8'(m_xmin), 8'(m_xmax), 1'b0, 7'(m_ymin), 1'b0, 7'(m_ymax)});
  endtask

  // Waits for the end of a clear; optionally keeps random plots streaming.
  task automatic wait_clear(input string tag, input bit hold_plot);
    int n;
    int early_ready;
    n = 0;
    early_ready = 0;
    vga_plot = hold_plot;
    do begin
      if (hold_plot) begin
        vga_x = 8'($urandom_range(0, 159));
        vga_y = 7'($urandom_range(0, 119));
        vga_colour = 3'($urandom_range(1, 7));
      end
      step();
      n++;
      if (ready && !clear_done) early_ready++;
    end while (!clear_done && n < 25000);
    vga_plot = 1'b0;
    check({tag, "_cycles"}, 32'(n), 32'd19200);
    check({tag, "_early_ready"}, 32'(early_ready), 32'd0);
    check({tag, "_ready_rise"}, 32'(ready), 32'd1);
    step();
    check({tag, "_done_pulse"}, 32'(clear_done), 32'd0);
    model_clear();
    check_stats(tag);
  endtask

  initial begin
    int x, y, c, rx, ry, exp_rd;
    bit p;
    logic [14:0] a;

    checks = 0; failures = 0;
    rst_n = 1'b0; clear_start = 1'b0;
    vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
    rd_x = '0; rd_y = '0;
    model_clear();

    // Reset state
    repeat (3) step();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_done", 32'(clear_done), 32'd0);
    check("rst_rd", 32'(rd_colour), 32'd0);
    check_stats("rst");

    // Reset-to-ready clear
    rst_n = 1'b1;
    wait_clear("init_clear", 1'b0);
    check_read("rd_0_0", 0, 0);
    check_read("rd_159_119", 159, 119);

    // Single plot then read-back
    plot(80, 60, 3'b010);
    check_read("rd_80_60", 80, 60);
    check("rd_80_60_const", 32'(rd_colour), 32'd2);
    check("pc_one", 32'(plot_count), 32'd1);
    check_stats("single");
    check_read("rd_81_60", 81, 60);

    // Out-of-range plots
    plot(160, 10, 3'b111);
    plot(5, 120, 3'b111);
    check("oob_two", 32'(oob_count), 32'd2);
    check_stats("oob");
    check_read("rd_5_119", 5, 119);
    check_read("rd_159_10", 159, 10);

    // Clear while plots keep streaming
    clear_start = 1'b1; vga_plot = 1'b1; vga_x = 8'd30; vga_y = 7'd30; vga_colour = 3'd6;
    step();
    clear_start = 1'b0;
    check("clr_enter_pc", 32'(plot_count), 32'd0);
    check("clr_enter_ready", 32'(ready), 32'd0);
    wait_clear("run_clear", 1'b1);
    check_read("clr_rd_80_60", 80, 60);
    check_read("clr_rd_30_30", 30, 30);

    // Bounding box growth and overwrite
    plot(60, 40, 3'b001);
    plot(100, 80, 3'b100);
    plot(60, 40, 3'b111);
    check("bbox_pc3", 32'(plot_count), 32'd3);
    check("bbox_box", {bbox_xmin, bbox_xmax, 1'b0, bbox_ymin, 1'b0, bbox_ymax},
          {8'd60, 8'd100, 8'd40, 8'd80});
    check_stats("bbox");
    check_read("rd_60_40", 60, 40);
    check("rd_60_40_const", 32'(rd_colour), 32'd7);

    // Read-before-write on the same pixel
    rd_x = 8'd10; rd_y = 7'd10;
    plot(10, 10, 3'b101);
    check("rbw_old", 32'(rd_colour), 32'd0);
    step();
    check("rbw_new", 32'(rd_colour), 32'd5);

    // Randomized back-to-back burst against the model
    for (int i = 0; i < 400; i++) begin
      x = $urandom_range(0, 175);
      y = $urandom_range(0, 127);
      c = $urandom_range(0, 7);
      p = ($urandom_range(0, 3) != 0);
      rx = $urandom_range(0, 170);
      ry = $urandom_range(0, 127);
      vga_x = 8'(x); vga_y = 7'(y); vga_colour = 3'(c); vga_plot = p;
      rd_x = 8'(rx); rd_y = 7'(ry);
      exp_rd = model_read(rx, ry);
      step();
      check("burst_rd", 32'(rd_colour), 32'(exp_rd));
      if (p) begin
        model_plot(x, y, c);
        if (x < 160 && y < 120) exp_q.push_back(15'(y * 160 + x));
      end
    end
    vga_plot = 1'b0;
    check_stats("burst");
    for (int i = 0; i < 40 && i < exp_q.size(); i++) begin
      a = exp_q[i];
      check_read("burst_back", int'(a) % 160, int'(a) / 160);
    end

    // Reset pulsed part-way through a clear
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    repeat (5000) step();
    check("midclr_ready", 32'(ready), 32'd0);
    rst_n = 1'b0;
    step();
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_pc", 32'(plot_count), 32'd0);
    check("midrst_rd", 32'(rd_colour), 32'd0);
    rst_n = 1'b1;
    wait_clear("rst_clear", 1'b0);
    for (int i = 0; i < 20 && i < exp_q.size(); i++) begin
      a = exp_q[i];
      check_read("reclear_back", int'(a) % 160, int'(a) / 160);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
